window3x3_filter: RTL and testbench

Streaming 3x3 neighbourhood filter that sits directly downstream of the two 8-bit line-buffer FIFOs. Each accepted beat takes three vertically aligned pixels: the current row plus the two delayed rows read out of the line buffers. The block builds a sliding 3x3 window from them and emits either a Gaussian-smoothed or a Sobel-magnitude pixel. Output is "valid-region only", so the output image is (IMG_W-2) x (IMG_H-2).

---
 rtl/window3x3_filter.sv | 169 ++++++++++++++++
 tb/tb_window3x3_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_filter.sv
// Streaming 3x3 neighbourhood filter fed by two line-buffer taps. Emits a
// Gaussian 1-2-1 or Sobel |Gx|+|Gy| pixel for the interior of each frame.
module window3x3_filter #(
  parameter int IMG_W = 98,
  parameter int IMG_H = 98
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       sof,
  input  logic [7:0] pix_in,
  input  logic [7:0] row1_in,
  input  logic [7:0] row2_in,
  input  logic       mode,
  output logic       out_valid,
  output logic [7:0] out_pix,
  output logic       frame_done,
  output logic       busy
);

  localparam int DATA_W = 8;
  localparam int CW     = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int RW     = (IMG_H > 2) ? $clog2(IMG_H) : 2;

  typedef enum logic [1:0] {IDLE, PRIME, ACTIVE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                start, accept, clr, at_eol, qualify, last_beat;
  logic [DATA_W-1:0]   new_col [3];
  logic [DATA_W-1:0]   win_p0  [3][3];
  logic                vld_p0, last_p0, mode_p0;
  logic [11:0]         gsum_c;
  logic [10:0]         gx_r, gx_l, gy_b, gy_t;
  logic signed [10:0]  gx_c, gy_c;
  logic [11:0]         gsum_p1;
  logic signed [10:0]  gx_p1, gy_p1;
  logic                vld_p1, last_p1, mode_p1;

  function automatic logic [DATA_W-1:0] gauss_scale(input logic [11:0] s);
    return DATA_W'(s >> 4);
  endfunction

  function automatic logic [DATA_W-1:0] sobel_mag(input logic signed [10:0] gx,
                                                  input logic signed [10:0] gy);
    logic [10:0] ax;
    logic [10:0] ay;
    logic [11:0] mag;
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    mag = 12'(ax) + 12'(ay);
    return (mag > 12'd255) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  endfunction

  // Beat decode: a sof beat always restarts at (0,0); IDLE ignores everything else.
  always_comb begin
    start     = in_valid && sof;
    accept    = in_valid && (sof || (state != IDLE));
    at_eol    = (col == CW'(IMG_W - 1));
    clr       = start || (col == '0);
    qualify   = accept && !sof && (col >= CW'(2)) && (row >= RW'(2));
    last_beat = qualify && at_eol && (row == RW'(IMG_H - 1));
    new_col[0] = row2_in;
    new_col[1] = row1_in;
    new_col[2] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME: begin
        if (start)                                        state_nx = PRIME;
        else if (accept && at_eol && (row == RW'(1)))     state_nx = ACTIVE;
      end
      ACTIVE: begin
        if (start)          state_nx = PRIME;
        else if (last_beat) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start) begin
      col <= CW'(1);
      row <= '0;
    end else if (accept) begin
      if (at_eol) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Stage p0: window shift; column 0 of each row starts from an empty window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_p0[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_p0[r][0] <= clr ? '0 : win_p0[r][1];
        win_p0[r][1] <= clr ? '0 : win_p0[r][2];
        win_p0[r][2] <= new_col[r];
      end
    end
  end

  always_comb begin
    gsum_c = 12'(win_p0[0][0]) + 12'(win_p0[0][2]) + 12'(win_p0[2][0]) + 12'(win_p0[2][2])
           + ((12'(win_p0[0][1]) + 12'(win_p0[1][0]) + 12'(win_p0[1][2]) + 12'(win_p0[2][1])) << 1)
           + (12'(win_p0[1][1]) << 2);
    gx_r = 11'(win_p0[0][2]) + (11'(win_p0[1][2]) << 1) + 11'(win_p0[2][2]);
    gx_l = 11'(win_p0[0][0]) + (11'(win_p0[1][0]) << 1) + 11'(win_p0[2][0]);
    gy_b = 11'(win_p0[2][0]) + (11'(win_p0[2][1]) << 1) + 11'(win_p0[2][2]);
    gy_t = 11'(win_p0[0][0]) + (11'(win_p0[0][1]) << 1) + 11'(win_p0[0][2]);
    gx_c = $signed(gx_r) - $signed(gx_l);
    gy_c = $signed(gy_b) - $signed(gy_t);
  end

  // Stage p1: partial results for both modes; the mode bit selects at p2.
  always_ff @(posedge clk) begin
    if (accept) mode_p0 <= mode;
    gsum_p1 <= gsum_c;
    gx_p1   <= gx_c;
    gy_p1   <= gy_c;
    mode_p1 <= mode_p0;
  end

  // Stage p2: output register; control drains every cycle regardless of in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      last_p0    <= 1'b0;
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pix    <= '0;
    end else begin
      vld_p0     <= qualify;
      last_p0    <= last_beat;
      vld_p1     <= vld_p0;
      last_p1    <= last_p0;
      out_valid  <= vld_p1;
      frame_done <= last_p1;
      if (vld_p1)
        out_pix <= mode_p1 ? sobel_mag(gx_p1, gy_p1) : gauss_scale(gsum_p1);
    end
  end

endmodule

// File: tb/tb_window3x3_filter.sv
// Randomized scoreboard bench for window3x3_filter on a small 8x6 frame,
// with a frame-array reference model and a decoupled output monitor.
`timescale 1ns/1ps
module tb_window3x3_filter;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NOUT = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       sof = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] pix_in = '0;
  logic [7:0] row1_in = '0;
  logic [7:0] row2_in = '0;
  logic       out_valid;
  logic [7:0] out_pix;
  logic       frame_done;
  logic       busy;

  window3x3_filter #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof(sof),
    .pix_in(pix_in), .row1_in(row1_in), .row2_in(row2_in), .mode(mode),
    .out_valid(out_valid), .out_pix(out_pix), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int pix;
    bit done;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   n_done = 0;
  int   img[H][W];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Reference: output centred at (y-1,x-1) computed straight from the frame.
  function automatic int ref_pix(input int y, input int x, input logic m);
    int p[3][3];
    int sum, gx, gy, mag;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = img[y - 2 + r][x - 2 + c];
    if (!m) begin
      sum = p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
          + p[2][0] + 2*p[2][1] + p[2][2];
      return sum / 16;
    end
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (mag > 255) ? 255 : mag;
  endfunction

  task automatic fill(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0:       img[y][x] = 100;
          1:       img[y][x] = (x >= 4) ? 255 : 0;
          default: img[y][x] = int'($urandom_range(255));
        endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      sof      = 1'($urandom);
      pix_in   = 8'($urandom);
      row1_in  = 8'($urandom);
      row2_in  = 8'($urandom);
      mode     = 1'($urandom);
    end
  endtask

  // Streams img raster order, stopping before beat (stop_x, stop_y).
  task automatic send_frame(input int stop_y, input int stop_x, input int gap_pct, input int msel);
    logic m;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == stop_y && x == stop_x) return;
        for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) idle(1);
        @(posedge clk); #1;
        m        = (msel == 2) ? 1'($urandom) : 1'(msel);
        in_valid = 1'b1;
        sof      = (x == 0 && y == 0);
        pix_in   = 8'(img[y][x]);
        row1_in  = (y >= 1) ? 8'(img[y-1][x]) : 8'($urandom);
        row2_in  = (y >= 2) ? 8'(img[y-2][x]) : 8'($urandom);
        mode     = m;
        if (y >= 2 && x >= 2)
          exp_q.push_back('{pix: ref_pix(y, x, m), done: (y == H-1 && x == W-1), cyc: cyc + 3});
      end
    end
  endtask

  task automatic run_frame(input string name, input int gap_pct, input int msel);
    int o0, d0;
    o0 = n_out;
    d0 = n_done;
    send_frame(H, 0, gap_pct, msel);
    idle(6);
    chk({name, "_outputs"}, n_out - o0, NOUT);
    chk({name, "_frame_done"}, n_done - d0, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_busy_idle"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: out_pix=%0d frame_done=%0b at cycle %0d, none expected",
                   out_pix, frame_done, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_out++;
          if (frame_done) n_done++;
          if (out_pix !== 8'(e.pix) || frame_done !== e.done || cyc != e.cyc) begin
            errors++;
            $display("FAIL output_pixel: got pix=%0d done=%0b cycle=%0d, want pix=%0d done=%0b cycle=%0d",
                     out_pix, frame_done, cyc, e.pix, e.done, e.cyc);
          end
        end
      end else if (frame_done) begin
        checks++;
        errors++;
        $display("FAIL lone_frame_done: frame_done=1 with out_valid=0, want 0 at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int o0, d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_pix", out_pix, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);

    fill(0);
    run_frame("const_gauss", 0, 0);
    run_frame("const_sobel", 0, 1);
    fill(1);
    run_frame("edge_sobel", 0, 1);
    run_frame("edge_gauss", 0, 0);
    run_frame("edge_sobel_gaps", 30, 1);
    run_frame("edge_gauss_gaps", 30, 0);
    for (int f = 0; f < 3; f++) begin
      fill(2);
      run_frame("random_frame", 30, 2);
    end

    // Restart with sof at beat (col 3, row 4) of a running frame.
    fill(1);
    o0 = n_out;
    d0 = n_done;
    send_frame(4, 3, 0, 1);
    @(negedge clk);
    chk("abort_busy_mid_frame", busy, 1);
    fill(2);
    send_frame(H, 0, 20, 2);
    idle(6);
    chk("abort_outputs", n_out - o0, 2 * (W - 2) + 1 + NOUT);
    chk("abort_frame_done", n_done - d0, 1);
    chk("abort_queue_empty", exp_q.size(), 0);

    // Synchronous reset in the middle of a frame.
    fill(2);
    send_frame(3, 5, 0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      sof      = 1'b0;
      pix_in   = 8'($urandom);
      row1_in  = 8'($urandom);
      row2_in  = 8'($urandom);
      mode     = 1'($urandom);
    end
    idle(4);
    chk("midreset_busy_no_sof", busy, 0);
    fill(2);
    run_frame("post_reset", 10, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
